// File: rtl/bus_demux_capture.sv
// Purpose : steers one word per cycle from a time-multiplexed shared bus into
//           N_CH per-channel holding registers, selected by the in_sel tag.
// Latency : 1 cycle from the accept edge to out_data/out_valid (no bypass).
// Backpr. : in_ready drops only while the addressed channel is full and not being
//           acked, or while Clear is high; other full channels never stall the bus.
//
// Ports:
//   Clock, Resetn      - rising-edge clock, asynchronous active-low reset
//   Clear              - synchronous flush of every channel valid flag
//   in_data/in_sel     - bus word and destination channel tag
//   in_valid/in_ready  - bus handshake; a word is accepted when both are high
//   out_data           - channel k in bits [k*DATA_W +: DATA_W]
//   out_valid/out_ack  - per-channel occupancy flag and consumer acknowledge
//   accept_cnt         - wrapping count of accepted words
module bus_demux_capture #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 2,
  parameter int N_CH   = 2 ** SEL_W
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     Clear,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ack,
  output logic [15:0]              accept_cnt
);

  // Channel FSM encoding; out_valid[k] is the state bit of channel k.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic accept;

  // An acked channel may be refilled on the same edge, so the ack of the
  // addressed channel counts as free space.
  assign in_ready = ~Clear & (~out_valid[in_sel] | out_ack[in_sel]);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      out_data   <= '0;
      out_valid  <= '0;
      accept_cnt <= '0;
    end else if (Clear) begin
      // Flush drops only the flags; held data and the counter are kept.
      // in_ready is low here, so no accept can coincide with the flush.
      out_valid <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (accept && (in_sel == SEL_W'(k))) begin
          out_data[k*DATA_W +: DATA_W] <= in_data;
          out_valid[k]                 <= ST_FULL;
        end else if (out_ack[k]) begin
          // Ack on an empty channel leaves it empty, so no state check needed.
          out_valid[k] <= ST_EMPTY;
        end
      end
      if (accept) begin
        accept_cnt <= accept_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_demux_capture.sv
module tb_bus_demux_capture;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 2;
  localparam int N_CH   = 4;

  logic                   Clock;
  logic                   Resetn;
  logic                   Clear;
  logic [DATA_W-1:0]      in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_CH*DATA_W-1:0] out_data;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        out_ack;
  logic [15:0]            accept_cnt;

  int vectors;
  int miscompares;

  bus_demux_capture #(.DATA_W(DATA_W), .SEL_W(SEL_W), .N_CH(N_CH)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Clear      (Clear),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .accept_cnt (accept_cnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic [3:0]  ack;
    logic        exp_rdy;
    logic [3:0]  exp_valid;
    logic [15:0] exp_cnt;
    int          chk_ch;
    logic [15:0] exp_slice;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] slice(input int k);
    return out_data[k*DATA_W +: DATA_W];
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    Resetn   = 1'b0;
    Clear    = 1'b0;
    in_data  = '0;
    in_sel   = '0;
    in_valid = 1'b0;
    out_ack  = '0;

    //        clr  vld sel  dat       ack      rdy  valid    cnt     ch slice
    vt[0]  = '{1'b0,1'b1,2'd2,16'hBEEF,4'b0000,1'b1,4'b0100,16'd1, 2,16'hBEEF};
    vt[1]  = '{1'b0,1'b0,2'd0,16'h0000,4'b0000,1'b1,4'b0100,16'd1, 0,16'h0000};
    vt[2]  = '{1'b0,1'b1,2'd1,16'h1111,4'b0000,1'b1,4'b0110,16'd2, 1,16'h1111};
    vt[3]  = '{1'b0,1'b1,2'd1,16'h2222,4'b0000,1'b0,4'b0110,16'd2, 1,16'h1111};
    vt[4]  = '{1'b0,1'b1,2'd1,16'h2222,4'b0010,1'b1,4'b0110,16'd3, 1,16'h2222};
    vt[5]  = '{1'b0,1'b0,2'd2,16'h0000,4'b0100,1'b1,4'b0010,16'd3, 2,16'hBEEF};
    vt[6]  = '{1'b0,1'b1,2'd3,16'h3333,4'b0000,1'b1,4'b1010,16'd4, 3,16'h3333};
    vt[7]  = '{1'b0,1'b1,2'd0,16'h0A0A,4'b0000,1'b1,4'b1011,16'd5, 0,16'h0A0A};
    vt[8]  = '{1'b0,1'b0,2'd0,16'h0000,4'b1001,1'b1,4'b0010,16'd5, 0,16'h0A0A};
    vt[9]  = '{1'b0,1'b0,2'd3,16'h0000,4'b1001,1'b1,4'b0010,16'd5, 3,16'h3333};
    vt[10] = '{1'b0,1'b1,2'd0,16'h0B0B,4'b0000,1'b1,4'b0011,16'd6, 0,16'h0B0B};
    vt[11] = '{1'b0,1'b1,2'd2,16'h0C0C,4'b0000,1'b1,4'b0111,16'd7, 2,16'h0C0C};
    vt[12] = '{1'b1,1'b1,2'd3,16'hDDDD,4'b0000,1'b0,4'b0000,16'd7, 3,16'h3333};
    vt[13] = '{1'b1,1'b1,2'd0,16'h9999,4'b1111,1'b0,4'b0000,16'd7, 0,16'h0B0B};
    vt[14] = '{1'b0,1'b1,2'd3,16'hEEEE,4'b1000,1'b1,4'b1000,16'd8, 3,16'hEEEE};

    // Reset state
    @(posedge Clock);
    @(posedge Clock);
    #1;
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset out_data", out_data, 64'h0);
    check("reset accept_cnt", 64'(accept_cnt), 64'h0);
    check("reset in_ready", 64'(in_ready), 64'h1);
    Resetn = 1'b1;

    // Table-driven vectors: in_ready checked before the edge, state after it
    for (int i = 0; i < 15; i++) begin
      Clear    = vt[i].clr;
      in_valid = vt[i].vld;
      in_sel   = vt[i].sel;
      in_data  = vt[i].dat;
      out_ack  = vt[i].ack;
      #1;
      check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vt[i].exp_rdy));
      @(posedge Clock);
      #1;
      check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vt[i].exp_valid));
      check($sformatf("v%0d accept_cnt", i), 64'(accept_cnt), 64'(vt[i].exp_cnt));
      check($sformatf("v%0d slice%0d", i, vt[i].chk_ch), 64'(slice(vt[i].chk_ch)),
            64'(vt[i].exp_slice));
    end
    Clear = 1'b0;

    // Counter wrap: every channel acked each cycle, so every word is accepted
    in_valid = 1'b1;
    out_ack  = 4'hF;
    for (int i = 0; i < 65535 - 8; i++) begin
      in_sel  = 2'(i);
      in_data = 16'(i);
      @(posedge Clock);
      #1;
    end
    check("cnt before wrap", 64'(accept_cnt), 64'hFFFF);
    check("last loop slice2", 64'(slice(2)), 64'hFFF6);
    in_sel  = 2'd3;
    in_data = 16'h7777;
    @(posedge Clock);
    #1;
    check("cnt after wrap", 64'(accept_cnt), 64'h0000);
    check("wrap word slice3", 64'(slice(3)), 64'h7777);

    // Async reset mid-cycle with a word pending
    in_sel  = 2'd1;
    in_data = 16'h5555;
    out_ack = 4'h0;
    #2;
    Resetn = 1'b0;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'h0);
    check("async rst out_data", out_data, 64'h0);
    check("async rst accept_cnt", 64'(accept_cnt), 64'h0);
    @(posedge Clock);
    #1;
    check("rst held out_valid", 64'(out_valid), 64'h0);
    check("rst held out_data", out_data, 64'h0);
    in_valid = 1'b0;
    Resetn   = 1'b1;
    @(posedge Clock);
    #1;
    check("post rst accept_cnt", 64'(accept_cnt), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_demux_capture.md
Name: bus_demux_capture

Overview:
- Receiving end of the shared-bus select path: takes one time-multiplexed word per cycle from a shared data bus and steers it, by select tag, into one of N_CH per-channel holding registers.
- Each channel holds its word with a valid flag until the consumer acknowledges it.
- Sits between the processor's shared bus driver and the per-destination registers.
- Provides backpressure so no word is ever lost.

Parameters:
DATA_W, 16, width of bus word and each channel register
SEL_W, 2, width of select tag
N_CH, 4, number of channels; fixed at 2**SEL_W, so every tag value is legal

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
Clear  input  1  synchronous flush of all channel valid flags
in_data  input  DATA_W  shared bus word
in_sel  input  SEL_W  destination channel tag
in_valid  input  1  bus word present this cycle
in_ready  output  1  block can accept the word addressed by in_sel
out_data  output  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
out_valid  output  N_CH  channel k holds an unconsumed word
out_ack  input  N_CH  consumer k takes its word this cycle
accept_cnt  output  16  total accepted words, wraps

Behaviour:
- Reset: async on Resetn low, regardless of Clock. out_data = 0, out_valid = 0, accept_cnt = 0. in_ready follows the combinational rule below.
- Clock and reset: single Clock domain; asynchronous, active-low Resetn.
- Per-channel FSM, two states:
  - EMPTY (out_valid[k]=0) -> FULL on accept to k.
  - FULL -> EMPTY on out_ack[k] with no accept to k.
  - FULL -> FULL on out_ack[k] with a simultaneous accept to k; the new word replaces the old.
- in_ready, combinational: in_ready = ~Clear & (~out_valid[in_sel] | out_ack[in_sel]).
  - Drain-and-refill in the same cycle is allowed.
  - in_ready depends only on the addressed channel. Other channels being full does not stall the bus.
- Accept: in_valid & in_ready at a rising edge.
  - out_data slice[in_sel] <= in_data; out_valid[in_sel] <= 1; accept_cnt <= accept_cnt + 1.
  - accept_cnt wraps 0xFFFF -> 0x0000.
  - Latency: the word is visible on out_data/out_valid in the cycle after the accept edge. Single-register stage, no bypass.
- in_valid with in_ready = 0: nothing is captured. The source holds in_data/in_sel until accepted.
- out_ack[k] while out_valid[k] = 0: ignored, no state change.
- Clearing a channel: out_data slice k is not cleared. Data is held and only out_valid drops.
- Multiple out_ack bits may be high in one cycle; each channel is handled independently.
- Clear = 1 at an edge:
  - All out_valid <= 0.
  - No accept occurs, since in_ready is 0.
  - out_data and accept_cnt unchanged.
  - Clear takes priority over acks.
- Resetn asserted mid-transfer: the pending word is dropped with no partial state; all channels return to EMPTY.

Test Plan:
1. Reset, then in_sel=2, in_data=0xBEEF, in_valid=1 for one cycle -> next cycle out_valid=4'b0100, slice 2=0xBEEF, accept_cnt=1; other slices remain 0.
2. Channel 1 FULL with 0x1111, no ack, in_sel=1, in_data=0x2222 held valid -> in_ready=0, slice 1 stays 0x1111. Pulse out_ack[1] -> same-edge accept, slice 1=0x2222, out_valid[1] stays 1.
3. Channel 1 FULL, in_sel=3, in_data=0x3333 -> in_ready=1 despite channel 1 full; out_valid=4'b1010.
4. Channels 0 and 3 FULL, out_ack=4'b1001 with in_valid=0 -> out_valid=0; slices 0/3 keep old data. A further ack with out_valid=0 -> no change.
5. Three channels FULL, Clear=1 with in_valid=1, in_sel=0 -> in_ready=0, out_valid=0 next cycle, accept_cnt unchanged.
6. Preload accept_cnt to 0xFFFF via 65535 accepts, then one more accept -> accept_cnt=0x0000. Drop Resetn asynchronously mid-cycle -> all outputs 0 immediately, before the next Clock edge.
